mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_DEPTH, default 4096, BRAM depth in 32-bit words; AW = clog2(MEM_DEPTH) (12 at default).
REQ-002 clock  in  1  single clock; all state updates on posedge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 if_req  in  1  instruction-fetch read request; held until if_ack.
REQ-005 if_addr  in  32  fetch byte address; bits [1:0] ignored.
REQ-006 if_ack  out  1  one-cycle fetch completion; rdata valid this cycle.
REQ-007 d_req  in  1  data request; held until d_ack.
REQ-008 d_we  in  1  1 = store, 0 = load.
REQ-009 d_addr  in  32  data byte address; bits [1:0] ignored.
REQ-010 d_wdata  in  32  store data, already lane-replicated.
REQ-011 d_wmask  in  4  store byte-enable mask.
REQ-012 d_ack  out  1  one-cycle data completion; load data valid on rdata.
REQ-013 ld_req  in  1  program-loader write request; held until ld_ack.
REQ-014 ld_wdata  in  32  loader word to write.
REQ-015 ld_ack  out  1  one-cycle loader write completion.
REQ-016 rdata  out  32  shared read-data return bus.
REQ-017 mem_read_enable  out  1  BRAM read strobe.
REQ-018 mem_write_enable  out  1  BRAM write strobe.
REQ-019 mem_mask_write  out  4  BRAM byte-write mask.
REQ-020 mem_addr  out  AW  BRAM word address, drives both read and write address ports.
REQ-021 mem_data_in  out  32  BRAM write data.
REQ-022 mem_data_out  in  32  BRAM registered read data, one-cycle latency.

Function
REQ-023 FSM states are IDLE, ACCESS, and RESP; each transaction takes exactly IDLE -> ACCESS -> RESP -> IDLE (3 cycles).
REQ-024 IDLE: fixed priority loader > data > fetch; the winner is latched as owner, and the BRAM controls are registered so they are valid throughout ACCESS.
REQ-025 IDLE with no req stays IDLE; all mem enables are 0.
REQ-026 ACCESS: exactly one enable is high for one cycle (read for fetch or load; write for store or loader).
REQ-027 Loader writes go to internal word pointer ld_ptr with mask 4'b1111; ld_ptr increments after each ld_ack and wraps from MEM_DEPTH-1 to 0.
REQ-028 Data store uses mem_addr = d_addr[AW+1:2] and mask = d_wmask; mask 4'b0000 still completes with d_ack.
REQ-029 RESP: only the owner's ack is 1, for exactly one cycle.
REQ-030 RESP for a read: rdata = mem_data_out; rdata is 0 in all other cycles.
REQ-031 Out-of-range address (any bit [31:AW+2] set): no enable is asserted in ACCESS, ack is still given in RESP, rdata = 0, and writes are dropped.
REQ-032 Requests are sampled only in IDLE; a requester must deassert req in the cycle after its ack, or it is re-granted as a new transaction.
REQ-033 Fetch may starve while loader or data requests remain continuously asserted.
REQ-034 The arbiter does not preempt: a request arriving during ACCESS or RESP waits for the next IDLE.

Reset
REQ-035 On reset: state = IDLE, ld_ptr = 0, and every output is 0 (acks, enables, mask, mem_addr, mem_data_in, rdata).
REQ-036 Reset mid-transaction aborts it: no ack is issued, and a pending BRAM strobe is deasserted in the cycle after reset.

Structure
REQ-037 Package mem_arb_pkg holds state_t, owner_t (NONE, LOADER, DATA, FETCH), and the MEM_DEPTH default.
REQ-038 One sub-module, mem_prio_sel: a combinational 3-way fixed-priority encoder returning owner_t.

Verification
REQ-039 if_req=1, if_addr=0x10, preload word 4 = 0xDEADBEEF -> mem_read_enable in cycle 1, if_ack with rdata=0xDEADBEEF in cycle 2.
REQ-040 d_req, if_req, and ld_req rise together -> grant order loader, then data, then fetch, with acks at cycles 2, 5, and 8.
REQ-041 Store d_addr=0x21, d_wdata=0xAAAAAAAA, d_wmask=0010, then load 0x20 -> byte 1 only changes, and the load returns 0x0000AA00 on a zeroed word.
REQ-042 Loader writes 4098 words with MEM_DEPTH=4096 -> ld_ptr wraps, and words 0 and 1 hold the last two values written.
REQ-043 d_addr=0x00010000, load -> no enables asserted, d_ack in cycle 2, rdata=0.
REQ-044 reset asserted during ACCESS of a store -> no d_ack, the BRAM word is unchanged or written once, and the FSM is in IDLE the next cycle.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the three-port BRAM arbiter.
package mem_arb_pkg;

  localparam int MEM_DEPTH_DEFAULT = 4096;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    LOADER = 2'd1,
    DATA   = 2'd2,
    FETCH  = 2'd3
  } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester handshakes plus the BRAM port, bundled for the arbiter.
// slave: the arbiter side; master: requesters and the memory itself.
interface mem_arbiter_if #(parameter int AW = 12);

  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wmask;
  logic        d_ack;

  logic        ld_req;
  logic [31:0] ld_wdata;
  logic        ld_ack;

  logic [31:0] rdata;

  logic          mem_read_enable;
  logic          mem_write_enable;
  logic [3:0]    mem_mask_write;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_data_in;
  logic [31:0]   mem_data_out;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata, d_wmask,
    input  ld_req, ld_wdata,
    input  mem_data_out,
    output if_ack, d_ack, ld_ack, rdata,
    output mem_read_enable, mem_write_enable, mem_mask_write, mem_addr, mem_data_in
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata, d_wmask,
    output ld_req, ld_wdata,
    output mem_data_out,
    input  if_ack, d_ack, ld_ack, rdata,
    input  mem_read_enable, mem_write_enable, mem_mask_write, mem_addr, mem_data_in
  );

endinterface

// File: rtl/mem_prio_sel.sv
// Fixed-priority pick among the three requesters: loader > data > fetch.
module mem_prio_sel
  import mem_arb_pkg::*;
(
  input  logic   i_ld_req,
  input  logic   i_d_req,
  input  logic   i_if_req,
  output owner_t o_owner
);

  // priority encode the raw request lines
  always_comb begin
    o_owner = NONE;
    if (i_ld_req)      o_owner = LOADER;
    else if (i_d_req)  o_owner = DATA;
    else if (i_if_req) o_owner = FETCH;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port BRAM arbiter for loader, data and fetch requesters.
//
//   state  | meaning
//   IDLE   | sample requests, latch owner and BRAM controls
//   ACCESS | BRAM strobe high for one cycle (unless address out of range)
//   RESP   | owner's ack high; read data passed through from BRAM
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int MEM_DEPTH = MEM_DEPTH_DEFAULT,
  localparam int AW        = $clog2(MEM_DEPTH)
) (
  input  logic          i_clock,
  input  logic          i_reset,
  mem_arbiter_if.slave  bus
);

  state_t        r_state;
  state_t        w_state_nxt;
  owner_t        r_owner;
  owner_t        w_winner;
  logic          r_is_read;
  logic          r_oor;
  logic          r_re;
  logic          r_wr;
  logic [3:0]    r_mask;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [AW-1:0] r_ld_ptr;

  logic          w_d_oor;
  logic          w_if_oor;
  logic          w_unused_addr_bits;

  // any address bit above the BRAM word range marks the access as out of range
  assign w_d_oor  = |bus.d_addr[31:AW+2];
  assign w_if_oor = |bus.if_addr[31:AW+2];

  // byte-offset bits are ignored by word-granular accesses
  assign w_unused_addr_bits = ^{bus.d_addr[1:0], bus.if_addr[1:0]};

  mem_prio_sel u_prio_sel (
    .i_ld_req (bus.ld_req),
    .i_d_req  (bus.d_req),
    .i_if_req (bus.if_req),
    .o_owner  (w_winner)
  );

  // state register
  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // next-state: fixed three-cycle walk once a request is granted
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_winner != NONE) w_state_nxt = ACCESS;
      ACCESS:  w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // latch owner and BRAM controls on grant; drop strobes after ACCESS; advance loader pointer on ack
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_owner   <= NONE;
      r_is_read <= 1'b0;
      r_oor     <= 1'b0;
      r_re      <= 1'b0;
      r_wr      <= 1'b0;
      r_mask    <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_ld_ptr  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_owner <= w_winner;
          case (w_winner)
            LOADER: begin
              r_is_read <= 1'b0;
              r_oor     <= 1'b0;
              r_addr    <= r_ld_ptr;
              r_wdata   <= bus.ld_wdata;
              r_mask    <= 4'b1111;
              r_wr      <= 1'b1;
              r_re      <= 1'b0;
            end
            DATA: begin
              r_is_read <= ~bus.d_we;
              r_oor     <= w_d_oor;
              r_addr    <= bus.d_addr[AW+1:2];
              r_wdata   <= bus.d_wdata;
              r_mask    <= (bus.d_we && !w_d_oor) ? bus.d_wmask : 4'b0000;
              r_wr      <= bus.d_we & ~w_d_oor;
              r_re      <= ~bus.d_we & ~w_d_oor;
            end
            FETCH: begin
              r_is_read <= 1'b1;
              r_oor     <= w_if_oor;
              r_addr    <= bus.if_addr[AW+1:2];
              r_mask    <= 4'b0000;
              r_wr      <= 1'b0;
              r_re      <= ~w_if_oor;
            end
            default: begin
              r_re   <= 1'b0;
              r_wr   <= 1'b0;
              r_mask <= 4'b0000;
            end
          endcase
        end
        ACCESS: begin
          r_re   <= 1'b0;
          r_wr   <= 1'b0;
          r_mask <= 4'b0000;
        end
        RESP: begin
          if (r_owner == LOADER) begin
            if (r_ld_ptr == AW'(MEM_DEPTH - 1)) r_ld_ptr <= '0;
            else                                r_ld_ptr <= r_ld_ptr + 1'b1;
          end
          r_owner   <= NONE;
          r_is_read <= 1'b0;
          r_oor     <= 1'b0;
        end
        default: begin
          r_re   <= 1'b0;
          r_wr   <= 1'b0;
          r_mask <= 4'b0000;
        end
      endcase
    end
  end

  assign bus.ld_ack = (r_state == RESP) && (r_owner == LOADER);
  assign bus.d_ack  = (r_state == RESP) && (r_owner == DATA);
  assign bus.if_ack = (r_state == RESP) && (r_owner == FETCH);

  // BRAM output is registered, so read data is only valid in RESP and passed straight through
  assign bus.rdata = ((r_state == RESP) && r_is_read && !r_oor) ? bus.mem_data_out : 32'h0;

  assign bus.mem_read_enable  = r_re;
  assign bus.mem_write_enable = r_wr;
  assign bus.mem_mask_write   = r_mask;
  assign bus.mem_addr         = r_addr;
  assign bus.mem_data_in      = r_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural byte-masked BRAM.
module tb_mem_arbiter;

  localparam int AW = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_err = 0;
  int n_chk = 0;

  logic          bd_clr = 1'b0;
  logic          bd_we  = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [31:0]   bd_data = '0;
  logic [31:0]   mem [0:4095];

  mem_arbiter_if #(.AW(AW)) bus ();

  mem_arbiter #(.MEM_DEPTH(4096)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // BRAM model: registered read, byte-masked write, plus a backdoor for preload/clear
  always @(posedge clk) begin
    if (bd_clr) begin
      for (int i = 0; i < 4096; i++) mem[i] <= '0;
      bus.mem_data_out <= '0;
    end else begin
      if (bd_we) mem[bd_addr] <= bd_data;
      if (bus.mem_write_enable)
        for (int b = 0; b < 4; b++)
          if (bus.mem_mask_write[b]) mem[bus.mem_addr][8*b +: 8] <= bus.mem_data_in[8*b +: 8];
      if (bus.mem_read_enable) bus.mem_data_out <= mem[bus.mem_addr];
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one data-port transaction; lat = cycle of d_ack after the grant edge (-1 on timeout)
  task automatic data_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] m, output int lat, output logic [31:0] rd,
                          output logic saw_en);
    bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wd; bus.d_wmask = m;
    lat = -1; rd = '0; saw_en = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      next_cyc();
      if (bus.mem_read_enable || bus.mem_write_enable) saw_en = 1'b1;
      if (bus.d_ack) begin
        lat = c;
        rd  = bus.rdata;
        break;
      end
    end
    bus.d_req = 1'b0;
    next_cyc();
  endtask

  int          lat;
  logic [31:0] rd;
  logic        saw_en;
  logic [2:0]  acks;
  logic [2:0]  exp_acks;
  int          n_ld;

  initial begin
    bus.if_req = 0; bus.if_addr = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0; bus.d_wmask = 0;
    bus.ld_req = 0; bus.ld_wdata = 0;
    bd_clr = 1'b1;
    @(negedge clk);
    next_cyc();
    next_cyc();
    rst = 1'b0; bd_clr = 1'b0;

    // reset state
    chk("rst_acks", {29'd0, bus.ld_ack, bus.d_ack, bus.if_ack}, 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_en", {30'd0, bus.mem_read_enable, bus.mem_write_enable}, 32'd0);
    chk("rst_mask", {28'd0, bus.mem_mask_write}, 32'd0);
    chk("rst_addr", {20'd0, bus.mem_addr}, 32'd0);
    chk("rst_wdata", bus.mem_data_in, 32'd0);
    next_cyc();
    chk("idle_en", {30'd0, bus.mem_read_enable, bus.mem_write_enable}, 32'd0);

    // fetch from preloaded word 4
    bd_we = 1'b1; bd_addr = 12'd4; bd_data = 32'hDEADBEEF;
    next_cyc();
    bd_we = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    next_cyc();
    chk("fetch_c1_re", {31'd0, bus.mem_read_enable}, 32'd1);
    chk("fetch_c1_addr", {20'd0, bus.mem_addr}, 32'd4);
    chk("fetch_c1_ack", {31'd0, bus.if_ack}, 32'd0);
    next_cyc();
    chk("fetch_c2_ack", {31'd0, bus.if_ack}, 32'd1);
    chk("fetch_c2_rdata", bus.rdata, 32'hDEADBEEF);
    chk("fetch_c2_re", {31'd0, bus.mem_read_enable}, 32'd0);
    bus.if_req = 1'b0;
    next_cyc();
    chk("fetch_c3_ack", {31'd0, bus.if_ack}, 32'd0);
    chk("fetch_c3_rdata", bus.rdata, 32'd0);

    // all three requests together: loader, data, fetch with acks at 2, 5, 8
    bus.ld_req = 1'b1; bus.ld_wdata = 32'h11111111;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h10;
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    for (int c = 1; c <= 9; c++) begin
      next_cyc();
      acks = {bus.ld_ack, bus.d_ack, bus.if_ack};
      exp_acks = (c == 2) ? 3'b100 : (c == 5) ? 3'b010 : (c == 8) ? 3'b001 : 3'b000;
      chk($sformatf("prio_acks_c%0d", c), {29'd0, acks}, {29'd0, exp_acks});
      if (c == 1) begin
        chk("prio_ld_we", {31'd0, bus.mem_write_enable}, 32'd1);
        chk("prio_ld_mask", {28'd0, bus.mem_mask_write}, 32'hF);
        chk("prio_ld_addr", {20'd0, bus.mem_addr}, 32'd0);
      end
      if (c == 5) chk("prio_d_rdata", bus.rdata, 32'hDEADBEEF);
      if (c == 8) chk("prio_if_rdata", bus.rdata, 32'hDEADBEEF);
      if (bus.ld_ack) bus.ld_req = 1'b0;
      if (bus.d_ack)  bus.d_req  = 1'b0;
      if (bus.if_ack) bus.if_req = 1'b0;
    end
    chk("prio_ld_word0", mem[0], 32'h11111111);

    // masked store of byte 1 into a zeroed word, then load it back
    data_txn(1'b1, 32'h21, 32'hAAAAAAAA, 4'b0010, lat, rd, saw_en);
    chk("st_lat", lat, 32'd2);
    data_txn(1'b0, 32'h20, 32'h0, 4'b0000, lat, rd, saw_en);
    chk("ld_lat", lat, 32'd2);
    chk("ld_byte1", rd, 32'h0000AA00);

    // masked store into a populated word leaves the other bytes alone
    bd_we = 1'b1; bd_addr = 12'd9; bd_data = 32'h11223344;
    next_cyc();
    bd_we = 1'b0;
    data_txn(1'b1, 32'h25, 32'hAAAAAAAA, 4'b0010, lat, rd, saw_en);
    chk("st_merge", mem[9], 32'h1122AA44);
    data_txn(1'b1, 32'h24, 32'hFFFFFFFF, 4'b0000, lat, rd, saw_en);
    chk("st_mask0_lat", lat, 32'd2);
    chk("st_mask0_word", mem[9], 32'h1122AA44);

    // out-of-range load and store
    data_txn(1'b0, 32'h00010000, 32'h0, 4'b0000, lat, rd, saw_en);
    chk("oor_ld_lat", lat, 32'd2);
    chk("oor_ld_rdata", rd, 32'd0);
    chk("oor_ld_en", {31'd0, saw_en}, 32'd0);
    data_txn(1'b1, 32'h00010020, 32'h12345678, 4'b1111, lat, rd, saw_en);
    chk("oor_st_lat", lat, 32'd2);
    chk("oor_st_en", {31'd0, saw_en}, 32'd0);
    chk("oor_st_word", mem[8], 32'h0000AA00);

    // reset during ACCESS of a store
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h30; bus.d_wdata = 32'h55555555; bus.d_wmask = 4'hF;
    next_cyc();
    chk("rstmid_we", {31'd0, bus.mem_write_enable}, 32'd1);
    rst = 1'b1; bus.d_req = 1'b0;
    next_cyc();
    chk("rstmid_ack", {31'd0, bus.d_ack}, 32'd0);
    chk("rstmid_we_off", {31'd0, bus.mem_write_enable}, 32'd0);
    rst = 1'b0;
    next_cyc();
    chk("rstmid_ack2", {31'd0, bus.d_ack}, 32'd0);
    chk("rstmid_word", {31'd0, (mem[12] === 32'h0) || (mem[12] === 32'h55555555)}, 32'd1);
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    next_cyc();
    next_cyc();
    chk("rstmid_idle_fetch", {31'd0, bus.if_ack}, 32'd1);
    bus.if_req = 1'b0;
    next_cyc();

    // loader writes 4098 words back to back; pointer restarted at 0 by the reset above
    n_ld = 0;
    bus.ld_req = 1'b1; bus.ld_wdata = 32'h10000000;
    for (int c = 0; c < 13000 && n_ld < 4098; c++) begin
      next_cyc();
      if (bus.ld_ack) begin
        n_ld++;
        bus.ld_wdata = 32'h10000000 + n_ld;
        if (n_ld == 4098) bus.ld_req = 1'b0;
      end
    end
    bus.ld_req = 1'b0;
    next_cyc();
    chk("wrap_count", n_ld, 32'd4098);
    chk("wrap_word0", mem[0], 32'h10001000);
    chk("wrap_word1", mem[1], 32'h10001001);
    chk("wrap_word2", mem[2], 32'h10000002);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
